reg_file_seq: RTL

- Initiator that drives the 4x4-bit register file's single access port: write_en, reg_no, val, and the combinational dout read-back.
- Accepts one micro-instruction at a time over a valid/ready handshake and turns it into a read/modify/write sequence against the register file.
- ADDI updates the flags register.
- Sits between the instruction source (decoder/testbench) and the register file; the register file's only driver.

---
 rtl/reg_file_seq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/reg_file_seq.sv
// Sequencer that drives the single access port of a small register file.
// It accepts one micro-instruction over a valid/ready handshake and expands it
// into a read / write / flag-write sequence. Bus outputs are registered on the
// posedge, so they stay steady through the register file's negedge capture.
module reg_file_seq #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned FLAG_REG = 3,
  parameter int unsigned DATA_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [9:0]        instr,
  output logic              instr_ready,
  output logic              rf_write_en,
  output logic [3:0]        rf_reg_no,
  output logic [DATA_W-1:0] rf_val,
  input  logic [DATA_W-1:0] rf_dout,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              err,
  output logic              busy
);

  typedef enum logic [2:0] {S_IDLE, S_RDSRC, S_WR, S_WRF, S_DONE} state_e;
  typedef enum logic [1:0] {OP_LDI, OP_ADDI, OP_MOV, OP_RD} op_e;

  localparam logic [4:0] NUM_REGS_L = 5'(NUM_REGS);
  localparam logic [3:0] FLAG_IDX   = 4'(FLAG_REG);
  localparam int unsigned MSB       = DATA_W - 1;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [3:0]          rd_q, rd_d;
  logic [3:0]          src_q, src_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   flags_q, flags_d;

  logic                we_q, we_d;
  logic [3:0]          reg_no_q, reg_no_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                err_q, err_d;

  // Scratch values for the decode and ALU paths.
  op_e                 in_op;
  logic                accept;
  logic                illegal;
  logic [DATA_W-1:0]   imm_ext;
  logic [DATA_W:0]     sum5;
  logic [DATA_W-1:0]   alu_res;

  // Ready only in IDLE and never while reset is held.
  assign instr_ready = (state_q == S_IDLE) && rst;
  assign busy        = (state_q != S_IDLE);
  assign accept      = instr_valid && instr_ready;

  assign rf_write_en = we_q;
  assign rf_reg_no   = reg_no_q;
  assign rf_val      = val_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign err         = err_q;

  // Next-state, next-output and ALU logic for the sequence.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    src_d       = src_q;
    result_d    = result_q;
    flags_d     = flags_q;
    we_d        = 1'b0;
    reg_no_d    = 4'd0;
    val_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    err_d       = 1'b0;
    in_op       = op_e'(instr[9:8]);
    illegal     = ({1'b0, instr[7:4]} >= NUM_REGS_L) ||
                  ((in_op == OP_MOV) && ({1'b0, instr[3:0]} >= NUM_REGS_L));
    imm_ext     = DATA_W'(src_q);
    sum5        = {1'b0, rf_dout} + {1'b0, imm_ext};
    alu_res     = (op_q == OP_ADDI) ? sum5[DATA_W-1:0] : rf_dout;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = in_op;
          rd_d  = instr[7:4];
          src_d = instr[3:0];
          if (illegal) begin
            state_d     = S_DONE;
            result_d    = '0;
            rsp_valid_d = 1'b1;
            err_d       = 1'b1;
          end else if (in_op == OP_LDI) begin
            state_d  = S_WR;
            result_d = DATA_W'(instr[3:0]);
            we_d     = 1'b1;
            reg_no_d = instr[7:4];
            val_d    = DATA_W'(instr[3:0]);
          end else begin
            state_d  = S_RDSRC;
            reg_no_d = (in_op == OP_MOV) ? instr[3:0] : instr[7:4];
          end
        end
      end
      S_RDSRC: begin
        if (op_q == OP_RD) begin
          state_d     = S_DONE;
          result_d    = rf_dout;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rf_dout;
        end else begin
          state_d  = S_WR;
          result_d = alu_res;
          we_d     = 1'b1;
          reg_no_d = rd_q;
          val_d    = alu_res;
          if (op_q == OP_ADDI) begin
            flags_d      = '0;
            flags_d[0]   = (alu_res == '0);
            flags_d[1]   = sum5[DATA_W];
            flags_d[2]   = alu_res[MSB];
            flags_d[3]   = (rf_dout[MSB] == imm_ext[MSB]) && (alu_res[MSB] != rf_dout[MSB]);
          end
        end
      end
      S_WR: begin
        if (op_q == OP_ADDI) begin
          state_d  = S_WRF;
          we_d     = 1'b1;
          reg_no_d = FLAG_IDX;
          val_d    = flags_q;
        end else begin
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = result_q;
        end
      end
      S_WRF: begin
        state_d     = S_DONE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = result_q;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, operand and registered bus outputs; reset clears the bus at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LDI;
      rd_q        <= 4'd0;
      src_q       <= 4'd0;
      result_q    <= '0;
      flags_q     <= '0;
      we_q        <= 1'b0;
      reg_no_q    <= 4'd0;
      val_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      src_q       <= src_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      we_q        <= we_d;
      reg_no_q    <= reg_no_d;
      val_q       <= val_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

endmodule
